// File: rtl/systolic_drain.sv
// Systolic array drain: deskews the bottom-row partial sums, applies optional ReLU,
// buffers aligned vectors in a small FIFO and serializes them one element per cycle.
module systolic_drain #(
  parameter int BitSize   = 8,
  parameter int Columns   = 4,
  parameter int FifoDepth = 4,
  parameter int Relu      = 1
) (
  input  logic                            clk,
  input  logic                            res_n,
  input  logic [Columns-1:0]              in_valid,
  input  logic [Columns-1:0][BitSize-1:0] in_partial_sum,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [BitSize-1:0]              out_data,
  output logic [$clog2(Columns)-1:0]      out_col,
  output logic                            out_last,
  output logic [$clog2(FifoDepth):0]      fifo_count,
  output logic                            overflow,
  output logic                            skew_err
);

  localparam int ColW = $clog2(Columns);
  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = PtrW + 1;
  localparam logic [ColW-1:0] LastCol   = ColW'(Columns - 1);
  localparam logic [CntW-1:0] FullCount = CntW'(FifoDepth);

  typedef logic [Columns-1:0][BitSize-1:0] vec_t;
  typedef enum logic {IDLE, SEND} state_t;

  logic [Columns-1:0] al_valid;
  vec_t               al_data;
  vec_t               relu_data;

  // Column c arrives c cycles after column 0, so it is delayed by Columns-1-c stages.
  for (genvar c = 0; c < Columns; c++) begin : g_col
    localparam int Depth = Columns - 1 - c;
    if (Depth == 0) begin : g_pass
      assign al_valid[c] = in_valid[c];
      assign al_data[c]  = in_partial_sum[c];
    end else begin : g_dly
      logic [Depth-1:0]              v_q;
      logic [Depth-1:0][BitSize-1:0] d_q;

      always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
          v_q <= '0;
          d_q <= '0;
        end else begin
          v_q[0] <= in_valid[c];
          d_q[0] <= in_partial_sum[c];
          for (int s = 1; s < Depth; s++) begin
            v_q[s] <= v_q[s-1];
            d_q[s] <= d_q[s-1];
          end
        end
      end

      assign al_valid[c] = v_q[Depth-1];
      assign al_data[c]  = d_q[Depth-1];
    end
  end

  always_comb begin
    relu_data = al_data;
    if (Relu != 0) begin
      for (int c = 0; c < Columns; c++) begin
        if (al_data[c][BitSize-1]) relu_data[c] = '0;
      end
    end
  end

  vec_t            mem [FifoDepth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  state_t          state;
  vec_t            shift_q;
  vec_t            head;
  logic            push_req;
  logic            pop;
  logic            can_push;
  logic            push;
  logic [ColW-1:0] next_col;

  assign head     = mem[rd_ptr];
  assign push_req = al_valid[0];
  assign pop      = (fifo_count != '0) &&
                    ((state == IDLE) || ((state == SEND) && out_ready && out_last));
  // A full FIFO still accepts a vector when the serializer frees a slot on the same edge.
  assign can_push = (fifo_count < FullCount) || pop;
  assign push     = push_req && can_push;
  assign next_col = out_col + 1'b1;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= relu_data;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      skew_err   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      if (push_req && !can_push) overflow <= 1'b1;
      if ((al_valid != '0) && (al_valid != '1)) skew_err <= 1'b1;
    end
  end

  // Serializer: shift_q[0] always holds the element currently presented on out_data.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= IDLE;
      shift_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state     <= SEND;
            shift_q   <= head;
            out_valid <= 1'b1;
            out_data  <= head[0];
            out_col   <= '0;
            out_last  <= 1'b0;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (!out_last) begin
              shift_q  <= shift_q >> BitSize;
              out_data <= shift_q[1];
              out_col  <= next_col;
              out_last <= (next_col == LastCol);
            end else if (pop) begin
              shift_q   <= head;
              out_data  <= head[0];
              out_col   <= '0;
              out_last  <= 1'b0;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: table of single vectors, multi-cycle corner sequences
// and a randomized run compared against a queue-based reference model.
module tb_systolic_drain;

  localparam int BitSize   = 8;
  localparam int Columns   = 4;
  localparam int FifoDepth = 4;

  typedef logic [Columns-1:0][BitSize-1:0] vec_t;
  typedef struct {
    vec_t stim;
    vec_t exp_relu;
    vec_t exp_pass;
  } vec_rec_t;

  logic       clk = 1'b0;
  logic       res_n;
  logic [Columns-1:0] in_valid;
  vec_t       in_partial_sum;
  logic       out_ready;

  logic       r_valid, r_last, r_ovf, r_skew;
  logic [7:0] r_data;
  logic [1:0] r_col;
  logic [2:0] r_count;
  logic       p_valid, p_last, p_ovf, p_skew;
  logic [7:0] p_data;
  logic [1:0] p_col;
  logic [2:0] p_count;

  systolic_drain #(.BitSize(BitSize), .Columns(Columns), .FifoDepth(FifoDepth), .Relu(1)) u_relu (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_partial_sum(in_partial_sum),
    .out_ready(out_ready), .out_valid(r_valid), .out_data(r_data), .out_col(r_col),
    .out_last(r_last), .fifo_count(r_count), .overflow(r_ovf), .skew_err(r_skew)
  );

  systolic_drain #(.BitSize(BitSize), .Columns(Columns), .FifoDepth(FifoDepth), .Relu(0)) u_pass (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_partial_sum(in_partial_sum),
    .out_ready(out_ready), .out_valid(p_valid), .out_data(p_data), .out_col(p_col),
    .out_last(p_last), .fifo_count(p_count), .overflow(p_ovf), .skew_err(p_skew)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [Columns-1:0] pend_v [16];
  vec_t               pend_d [16];
  logic               arr_v  [16];
  vec_t               arr_d  [16];
  vec_rec_t           tbl    [4];

  vec_t m_q [$];
  vec_t m_cur;
  logic m_busy;
  int   m_idx;
  logic m_ovf;

  function automatic logic [7:0] relu8(input logic [7:0] x);
    return x[7] ? 8'h00 : x;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_elem(input string tag, input logic [7:0] er, input logic [7:0] ep, input int col);
    check_output({tag, " valid"}, r_valid, 1);
    check_output({tag, " data"}, r_data, er);
    check_output({tag, " col"}, r_col, col);
    check_output({tag, " last"}, r_last, col == Columns - 1);
    check_output({tag, " pass valid"}, p_valid, 1);
    check_output({tag, " pass data"}, p_data, ep);
  endtask

  // Schedules a skewed vector: column c enters c cycles after column 0 (next cycle).
  task automatic launch(input vec_t v, input int late_col);
    for (int c = 0; c < Columns; c++) begin
      int slot;
      slot = (cyc + 1 + c + ((c == late_col) ? 1 : 0)) % 16;
      pend_v[slot][c] = 1'b1;
      pend_d[slot][c] = v[c];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    in_valid       = pend_v[cyc % 16];
    in_partial_sum = pend_d[cyc % 16];
    pend_v[cyc % 16] = '0;
    pend_d[cyc % 16] = '0;
  endtask

  task automatic goto_cycle(input int t);
    while (cyc < t) step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    res_n          = 1'b0;
    out_ready      = 1'b1;
    in_valid       = '0;
    in_partial_sum = '0;
    for (int i = 0; i < 16; i++) begin
      pend_v[i] = '0;
      pend_d[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    res_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic apply_stimulus(input vec_rec_t rec, input int n);
    string tag;
    tag = $sformatf("tbl%0d", n);
    do_reset();
    launch(rec.stim, -1);
    goto_cycle(5);
    check_output({tag, " early valid"}, r_valid, 0);
    check_output({tag, " count"}, r_count, 1);
    for (int k = 0; k < Columns; k++) begin
      goto_cycle(6 + k);
      check_elem($sformatf("%s e%0d", tag, k), rec.exp_relu[k], rec.exp_pass[k], k);
    end
    goto_cycle(10);
    check_output({tag, " end valid"}, r_valid, 0);
    check_output({tag, " end count"}, r_count, 0);
  endtask

  task automatic model_check_and_update();
    logic pop;
    logic room;
    check_output("rnd valid", r_valid, m_busy);
    check_output("rnd count", r_count, m_q.size());
    check_output("rnd ovf", r_ovf, m_ovf);
    check_output("rnd skew", r_skew, 0);
    if (m_busy) begin
      check_output("rnd data", r_data, relu8(m_cur[m_idx]));
      check_output("rnd pass data", p_data, m_cur[m_idx]);
      check_output("rnd col", r_col, m_idx);
      check_output("rnd last", r_last, m_idx == Columns - 1);
    end
    pop  = (m_q.size() > 0) && (!m_busy || (out_ready && m_idx == Columns - 1));
    room = (m_q.size() < FifoDepth) || pop;
    if (m_busy && out_ready && m_idx < Columns - 1) m_idx++;
    else if (pop) begin
      m_cur  = m_q.pop_front();
      m_idx  = 0;
      m_busy = 1'b1;
    end else if (m_busy && out_ready) m_busy = 1'b0;
    if (arr_v[cyc % 16]) begin
      if (room) m_q.push_back(arr_d[cyc % 16]);
      else m_ovf = 1'b1;
    end
    arr_v[cyc % 16] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl[0] = '{{8'd40, 8'd30, 8'd20, 8'd10}, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd40, 8'd30, 8'd20, 8'd10}};
    tbl[1] = '{{8'h01, 8'hFF, 8'h7F, 8'h85}, {8'h01, 8'h00, 8'h7F, 8'h00}, {8'h01, 8'hFF, 8'h7F, 8'h85}};
    tbl[2] = '{{8'h80, 8'h00, 8'hFE, 8'h7E}, {8'h00, 8'h00, 8'h00, 8'h7E}, {8'h80, 8'h00, 8'hFE, 8'h7E}};
    tbl[3] = '{{8'hC3, 8'h3C, 8'h81, 8'h7F}, {8'h00, 8'h3C, 8'h00, 8'h7F}, {8'hC3, 8'h3C, 8'h81, 8'h7F}};

    res_n          = 1'b0;
    out_ready      = 1'b1;
    in_valid       = '0;
    in_partial_sum = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset valid", r_valid, 0);
    check_output("reset data", r_data, 0);
    check_output("reset col", r_col, 0);
    check_output("reset last", r_last, 0);
    check_output("reset count", r_count, 0);
    check_output("reset ovf", r_ovf, 0);
    check_output("reset skew", r_skew, 0);

    for (int i = 0; i < 4; i++) apply_stimulus(tbl[i], i);

    // Backpressure: ready low on the edges ending cycles 7..10.
    do_reset();
    launch({8'd40, 8'd30, 8'd20, 8'd10}, -1);
    goto_cycle(6);
    check_elem("bp e0", 8'd10, 8'd10, 0);
    goto_cycle(7);
    check_elem("bp e1", 8'd20, 8'd20, 1);
    out_ready = 1'b0;
    for (int t = 8; t <= 11; t++) begin
      goto_cycle(t);
      check_elem($sformatf("bp hold%0d", t), 8'd20, 8'd20, 1);
    end
    out_ready = 1'b1;
    goto_cycle(12);
    check_elem("bp e2", 8'd30, 8'd30, 2);
    goto_cycle(13);
    check_elem("bp e3", 8'd40, 8'd40, 3);
    goto_cycle(14);
    check_output("bp idle", r_valid, 0);

    // Overflow: six back-to-back vectors with the sink stalled.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      launch({8'(16 * i + 4), 8'(16 * i + 3), 8'(16 * i + 2), 8'(16 * i + 1)}, -1);
      step();
    end
    goto_cycle(9);
    check_output("ovf before", r_ovf, 0);
    check_output("ovf count before", r_count, 4);
    goto_cycle(10);
    check_output("ovf flag", r_ovf, 1);
    check_output("ovf count", r_count, 4);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) goto_cycle(10 + k);
      check_elem($sformatf("ovf drain%0d", k), 8'(16 * (k / 4) + (k % 4) + 1),
                 8'(16 * (k / 4) + (k % 4) + 1), k % 4);
    end
    goto_cycle(30);
    check_output("ovf end valid", r_valid, 0);
    check_output("ovf end count", r_count, 0);
    check_output("ovf sticky", r_ovf, 1);

    // Skew fault: column 2 one cycle late.
    do_reset();
    launch({8'd40, 8'd30, 8'd20, 8'd10}, 2);
    goto_cycle(4);
    check_output("skew before", r_skew, 0);
    goto_cycle(5);
    check_output("skew set", r_skew, 1);
    goto_cycle(6);
    check_elem("skew e0", 8'd10, 8'd10, 0);
    goto_cycle(7);
    check_elem("skew e1", 8'd20, 8'd20, 1);
    goto_cycle(8);
    check_elem("skew e2", 8'd0, 8'd0, 2);
    goto_cycle(9);
    check_elem("skew e3", 8'd40, 8'd40, 3);
    goto_cycle(10);
    check_output("skew one vector", r_count, 0);
    check_output("skew idle", r_valid, 0);
    goto_cycle(20);
    check_output("skew sticky", r_skew, 1);

    // Reset while sending column 2 with another vector buffered.
    do_reset();
    launch({8'd40, 8'd30, 8'd20, 8'd10}, -1);
    step();
    launch({8'd4, 8'd3, 8'd2, 8'd1}, -1);
    goto_cycle(8);
    check_output("mid col", r_col, 2);
    check_output("mid count", r_count, 1);
    res_n = 1'b0;
    #1;
    check_output("async valid", r_valid, 0);
    check_output("async count", r_count, 0);
    check_output("async col", r_col, 0);
    check_output("async data", r_data, 0);
    do_reset();
    launch({8'h44, 8'h33, 8'h22, 8'h11}, -1);
    goto_cycle(5);
    check_output("post rst early", r_valid, 0);
    for (int k = 0; k < Columns; k++) begin
      goto_cycle(6 + k);
      check_elem($sformatf("post rst e%0d", k), 8'(8'h11 * (k + 1)), 8'(8'h11 * (k + 1)), k);
    end
    goto_cycle(10);
    check_output("post rst idle", r_valid, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 16; i++) arr_v[i] = 1'b0;
    m_q.delete();
    m_busy = 1'b0;
    m_idx  = 0;
    m_ovf  = 1'b0;
    m_cur  = '0;
    for (int n = 0; n < 700; n++) begin
      int rdy_pct;
      int lau_pct;
      if (n < 300)      begin rdy_pct = 90;  lau_pct = 15; end
      else if (n < 620) begin rdy_pct = 60;  lau_pct = 40; end
      else              begin rdy_pct = 100; lau_pct = 0;  end
      step();
      out_ready = ($urandom_range(99) < rdy_pct);
      if ($urandom_range(99) < lau_pct) begin
        vec_t v;
        v = $urandom;
        launch(v, -1);
        arr_v[(cyc + 4) % 16] = 1'b1;
        arr_d[(cyc + 4) % 16] = v;
      end
      @(negedge clk);
      model_check_and_update();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
